// File: rtl/tape_recorder.sv
// -----------------------------------------------------------------------------
// tape_recorder
//
// Captures the machine's cassette output stream into a byte buffer so it can
// later be saved as a .TAP image. The period between rising edges of the tape
// signal is measured, each period is classified as a 1 (short) or 0 (long)
// bit, and Oric serial frames (start 0, 8 data bits LSB first, odd parity,
// stop/leader 1s) are deframed into bytes written sequentially to a RAM.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   en          cassette motor relay; recording is active while high
//   tape_out    raw tape output level (asynchronous to clk)
//   rewind      one-cycle pulse; clears write pointer, length and sticky flags
//   wr_en       one-cycle write strobe to the capture RAM
//   wr_addr     RAM address of the byte being written
//   wr_data     decoded byte
//   rec_len     number of bytes captured so far
//   overflow    sticky; a byte arrived while the buffer was full
//   parity_err  sticky; at least one byte failed parity
//   busy        deframer is inside a frame
// -----------------------------------------------------------------------------
module tape_recorder #(
    parameter int CLK_KHZ      = 24000,
    parameter int SHORT_MAX_US = 312,
    parameter int LONG_MAX_US  = 624,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              tape_out,
    input  logic              rewind,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W:0]   rec_len,
    output logic              overflow,
    output logic              parity_err,
    output logic              busy
);

    // Period thresholds in clock counts.
    localparam logic [15:0] S_TH = 16'(CLK_KHZ * SHORT_MAX_US / 1000);
    localparam logic [15:0] L_TH = 16'(CLK_KHZ * LONG_MAX_US / 1000);

    // rec_len value that means the buffer is completely full.
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        sync1;
    logic        sync2;
    logic        sync_d;
    logic        rise;
    logic [15:0] cnt;
    logic        have_ref;
    logic        gap;
    logic        bit_valid;
    logic        bit_val;
    logic [7:0]  sr;
    logic [2:0]  bitcnt;
    logic        byte_done;
    logic        par_bad;

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync1  <= tape_out;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign rise = sync2 & ~sync_d;

    // A gap is a period that reached the long limit without an edge.
    // A bit is only produced when a reference edge exists and the period is
    // shorter than the long limit.
    assign gap       = (cnt == L_TH);
    assign bit_valid = en & rise & have_ref & (cnt < L_TH);
    assign bit_val   = (cnt < S_TH);
    assign par_bad   = (bit_val != ~^sr);

    // Period counter and reference flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= 16'd0;
            have_ref <= 1'b0;
        end else if (!en) begin
            cnt      <= 16'd0;
            have_ref <= 1'b0;
        end else if (rise) begin
            cnt      <= 16'd0;
            have_ref <= 1'b1;
        end else begin
            if (!gap) begin
                cnt <= cnt + 16'd1;
            end
            if (gap) begin
                have_ref <= 1'b0;
            end
        end
    end

    // Deframer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Deframer next state; byte_done flags the parity cell being closed.
    always_comb begin
        state_next = state;
        byte_done  = 1'b0;
        if (!en || rewind) begin
            state_next = IDLE;
        end else if (bit_valid) begin
            case (state)
                IDLE: begin
                    if (!bit_val) begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (bitcnt == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    state_next = IDLE;
                    byte_done  = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end else if (gap) begin
            state_next = IDLE;
        end
    end

    // Data shift register, LSB first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr     <= 8'd0;
            bitcnt <= 3'd0;
        end else if (bit_valid) begin
            case (state)
                IDLE: bitcnt <= 3'd0;
                DATA: begin
                    sr     <= {bit_val, sr[7:1]};
                    bitcnt <= bitcnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Buffer write side. rec_len doubles as the write pointer; it stops at
    // FULL rather than wrapping. rewind wins over a write in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'd0;
            rec_len    <= '0;
            overflow   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (rewind) begin
                rec_len    <= '0;
                overflow   <= 1'b0;
                parity_err <= 1'b0;
            end else if (byte_done) begin
                if (par_bad) begin
                    parity_err <= 1'b1;
                end
                if (rec_len == FULL) begin
                    overflow <= 1'b1;
                end else begin
                    wr_en   <= 1'b1;
                    wr_addr <= rec_len[ADDR_W-1:0];
                    wr_data <= sr;
                    rec_len <= rec_len + 1'b1;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
